// File: rtl/magnitude_peak_detector.sv
// Magnitude peak detector: reads back per-frame 64-bit magnitude sums (low word,
// then high word) over an Avalon master, tracks the peak sum and its frame index,
// and counts frames whose sum strictly exceeds a software threshold.
// Configuration and results are exposed through an Avalon slave register file.
module magnitude_peak_detector #(
    parameter int avs_avalonslave_data_width     = 32,
    parameter int avs_avalonslave_address_width  = 4,
    parameter int avm_avalonmaster_data_width    = 32,
    parameter int avm_avalonmaster_address_width = 32
) (
    input  logic                                      csi_clock_clk,
    input  logic                                      csi_clock_reset_n,
    input  logic [avs_avalonslave_address_width-1:0]  avs_avalonslave_address,
    input  logic                                      avs_avalonslave_read,
    input  logic                                      avs_avalonslave_write,
    input  logic [avs_avalonslave_data_width-1:0]     avs_avalonslave_writedata,
    output logic [avs_avalonslave_data_width-1:0]     avs_avalonslave_readdata,
    output logic [avm_avalonmaster_address_width-1:0] avm_avalonmaster_address,
    output logic                                      avm_avalonmaster_read,
    input  logic                                      avm_avalonmaster_waitrequest,
    input  logic [avm_avalonmaster_data_width-1:0]    avm_avalonmaster_readdata,
    output logic                                      DONE
);

    localparam int SW = avs_avalonslave_data_width;
    localparam int MW = avm_avalonmaster_data_width;
    localparam int AW = avm_avalonmaster_address_width;

    typedef enum logic [2:0] {S_IDLE, S_RD_LO, S_RD_HI, S_CMP, S_FIN} state_t;

    // The port is named _n but the block resets while it is high.
    logic rst;
    assign rst = csi_clock_reset_n;

    state_t            r_state;
    state_t            w_next;

    // Software-visible configuration.
    logic [11:0]       r_ctrl;
    logic [MW-1:0]     r_src;
    logic [MW-1:0]     r_thr_lo;
    logic [MW-1:0]     r_thr_hi;

    // Run snapshot, latched while idle so config writes mid-run do not disturb it.
    logic [10:0]       r_num;
    logic [2*MW-1:0]   r_thr;
    logic [AW-1:0]     r_ptr;

    // Running state of the current run.
    logic [MW-1:0]     r_lo;
    logic [MW-1:0]     r_hi;
    logic [2*MW-1:0]   r_max;
    logic [10:0]       r_idx;
    logic [10:0]       r_cnt;
    logic [10:0]       r_frame;

    // Published results, updated only when the run completes.
    logic [2*MW-1:0]   r_res_max;
    logic [10:0]       r_res_idx;
    logic [10:0]       r_res_cnt;

    logic [SW-1:0]     r_readdata;

    logic              w_start;
    logic              w_busy;
    logic [2*MW-1:0]   w_sum;
    logic              w_take;
    logic [2*MW-1:0]   w_new_max;
    logic [10:0]       w_new_idx;
    logic [10:0]       w_new_cnt;
    logic [10:0]       w_frame_inc;
    logic              w_last;
    logic [SW-1:0]     w_rd_mux;

    assign w_start     = r_ctrl[0];
    assign w_busy      = (r_state == S_RD_LO) || (r_state == S_RD_HI) || (r_state == S_CMP);
    assign w_sum       = {r_hi, r_lo};
    // Strict compare so that the first frame reaching a given peak keeps the index.
    assign w_take      = (r_frame == 11'd0) || (w_sum > r_max);
    assign w_new_max   = w_take ? w_sum : r_max;
    assign w_new_idx   = w_take ? r_frame : r_idx;
    assign w_new_cnt   = (w_sum > r_thr) ? (r_cnt + 11'd1) : r_cnt;
    assign w_frame_inc = r_frame + 11'd1;
    assign w_last      = (w_frame_inc == r_num);

    assign avm_avalonmaster_read    = (r_state == S_RD_LO) || (r_state == S_RD_HI);
    assign avm_avalonmaster_address = r_ptr;
    assign avs_avalonslave_readdata = r_readdata;
    assign DONE                     = (r_state == S_FIN);

    // State register.
    always_ff @(posedge csi_clock_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; master handshakes advance only when the fabric is not stalling.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = (r_ctrl[11:1] == 11'd0) ? S_FIN : S_RD_LO;
            S_RD_LO: if (!avm_avalonmaster_waitrequest) w_next = S_RD_HI;
            S_RD_HI: if (!avm_avalonmaster_waitrequest) w_next = S_CMP;
            S_CMP:   w_next = w_last ? S_FIN : S_RD_LO;
            S_FIN:   if (!w_start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Slave read mux; unmapped addresses return zero.
    always_comb begin
        w_rd_mux = '0;
        case (avs_avalonslave_address)
            4'd0: w_rd_mux = SW'(r_ctrl);
            4'd1: w_rd_mux = r_src;
            4'd2: w_rd_mux = r_thr_lo;
            4'd3: w_rd_mux = r_thr_hi;
            4'd4: w_rd_mux = SW'({w_busy, DONE});
            4'd5: w_rd_mux = r_res_max[MW-1:0];
            4'd6: w_rd_mux = r_res_max[2*MW-1:MW];
            4'd7: w_rd_mux = SW'(r_res_idx);
            4'd8: w_rd_mux = SW'(r_res_cnt);
            default: w_rd_mux = '0;
        endcase
    end

    // Register file, run snapshot, frame datapath and result publication.
    always_ff @(posedge csi_clock_clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_src      <= '0;
            r_thr_lo   <= '0;
            r_thr_hi   <= '0;
            r_num      <= '0;
            r_thr      <= '0;
            r_ptr      <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_max      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_frame    <= '0;
            r_res_max  <= '0;
            r_res_idx  <= '0;
            r_res_cnt  <= '0;
            r_readdata <= '0;
        end else begin
            if (avs_avalonslave_write) begin
                case (avs_avalonslave_address)
                    4'd0: r_ctrl   <= avs_avalonslave_writedata[11:0];
                    4'd1: r_src    <= avs_avalonslave_writedata;
                    4'd2: r_thr_lo <= avs_avalonslave_writedata;
                    4'd3: r_thr_hi <= avs_avalonslave_writedata;
                    default: ;
                endcase
            end
            if (avs_avalonslave_read) r_readdata <= w_rd_mux;

            case (r_state)
                S_IDLE: begin
                    r_num   <= r_ctrl[11:1];
                    r_thr   <= {r_thr_hi, r_thr_lo};
                    r_ptr   <= r_src;
                    r_max   <= '0;
                    r_idx   <= '0;
                    r_cnt   <= '0;
                    r_frame <= '0;
                    if (w_start) begin
                        r_res_max <= '0;
                        r_res_idx <= '0;
                        r_res_cnt <= '0;
                    end
                end
                S_RD_LO: begin
                    if (!avm_avalonmaster_waitrequest) begin
                        r_lo  <= avm_avalonmaster_readdata;
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                S_RD_HI: begin
                    if (!avm_avalonmaster_waitrequest) begin
                        r_hi  <= avm_avalonmaster_readdata;
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                S_CMP: begin
                    r_max   <= w_new_max;
                    r_idx   <= w_new_idx;
                    r_cnt   <= w_new_cnt;
                    r_frame <= w_frame_inc;
                    if (w_last) begin
                        r_res_max <= w_new_max;
                        r_res_idx <= w_new_idx;
                        r_res_cnt <= w_new_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
